arbitro_jogadas: RTL and testbench
==================================

ARBITRO_JOGADAS -- requirements
Module: arbitro_jogadas

Interface
REQ-001 Parameter: TIMEOUT_ACK, default 16, cycles BLOQ waits for bloq_ack before dropping the request (range 1..255).
REQ-002 Port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: jogo_ativo  in  1  game running; when low, no events are accepted.
REQ-005 Port: acerto_j1, erro_j1, acerto_j2, erro_j2  in  1 each  level inputs, synchronous to clk; one event per rising edge.
REQ-006 Port: linhas_j1, linhas_j2  in  3 each  blocking-line count from each player's score counter.
REQ-007 Port: acertou, errou  out  1 each  shared hit/miss pulse to both score counters.
REQ-008 Port: enable_j1, enable_j2  out  1 each  one-hot select of the score counter being updated.
REQ-009 Port: bloq_req  out  1; bloq_alvo  out  1 (0 = player 1, 1 = player 2); bloq_qtd  out  3  blocking-line push request to the opponent board.
REQ-010 Port: bloq_ack  in  1  opponent board accepted the push.
REQ-011 Port: bloq_perdido  out  1  one-cycle pulse when a push times out; ocupado  out  1  high in any state other than OCIOSO.

Function
REQ-012 Event detect: registered copy of each event input; event = input high and registered copy low, while jogo_ativo high.
REQ-013 Four pending flags (one per event input); a detected event sets its flag; a new event on an already-set flag is dropped.
REQ-014 Pending flags are set in every FSM state; set and clear of the same flag in the same cycle: set wins.
REQ-015 FSM states: OCIOSO, APLICA, ESPERA, COMPARA, BLOQ; all outputs are registered.
REQ-016 OCIOSO: if any flag is pending, select a player, then -> APLICA; otherwise stay.
REQ-017 Player selection is round-robin: if both players have pending flags, select the player other than the one last served; otherwise select the only requester.
REQ-018 Within the selected player, acerto has priority over erro; the other flag stays pending.
REQ-019 APLICA (1 cycle): drive the selected enable_jx and acertou or errou high for exactly one cycle; clear that flag; record last-served player; -> ESPERA.
REQ-020 ESPERA (1 cycle): no outputs asserted; lets the counter update and linhas settle; -> COMPARA.
REQ-021 COMPARA: compare the served player's linhas_jx with its stored value linhas_ant_jx; always load linhas_ant_jx with linhas_jx.
REQ-022 In COMPARA, if linhas_jx > linhas_ant_jx: bloq_qtd = difference (3-bit, unsigned), bloq_alvo = the other player, -> BLOQ; otherwise -> OCIOSO.
REQ-023 BLOQ: bloq_req, bloq_alvo and bloq_qtd are held stable.
REQ-024 BLOQ: bloq_ack sampled high -> deassert bloq_req next cycle, -> OCIOSO.
REQ-025 BLOQ: TIMEOUT_ACK cycles without bloq_ack -> deassert bloq_req, pulse bloq_perdido for one cycle, -> OCIOSO.
REQ-026 Latency: input rising edge sampled at clk edge k -> acertou/errou pulse high during the cycle after edge k+2, if the FSM is idle.
REQ-027 jogo_ativo low: all pending flags are cleared and the FSM is forced to OCIOSO on the next edge from any state.
REQ-028 jogo_ativo low: bloq_req, enable_jx, acertou, errou are deasserted, and linhas_ant_j1/j2 track linhas_j1/j2 every cycle.

Reset
REQ-029 reset_n low asynchronously forces state OCIOSO and clears all pending flags, registered input copies and linhas_ant values.
REQ-030 reset_n low sets last-served to player 2, so player 1 wins the first tie.
REQ-031 reset_n low drives every output to 0; normal operation resumes on the first clk edge after reset_n rises.

Verification
REQ-032 Single hit: jogo_ativo=1, acerto_j1 rises at edge k -> enable_j1=1 and acertou=1 for exactly one cycle after edge k+2, errou=0, enable_j2=0.
REQ-033 Tie and fairness: acerto_j1 and acerto_j2 rise in the same cycle after reset -> player 1 served first, player 2 served next in APLICA, about 4 cycles later; no event lost.
REQ-034 Block push: linhas_j1 changes 0->1 after the served hit -> bloq_req=1, bloq_alvo=1, bloq_qtd=1 held until bloq_ack; bloq_req drops the cycle after ack.
REQ-035 Timeout: BLOQ entered, bloq_ack held 0 -> after 16 cycles bloq_req=0, bloq_perdido one-cycle pulse, ocupado=0.
REQ-036 Abort and reset: jogo_ativo=0 during BLOQ -> bloq_req=0 next cycle, pending cleared. reset_n=0 mid-APLICA -> acertou/enable drop immediately without waiting for clk.

Source files
------------

// File: rtl/arbitro_jogadas.sv
// Serialises hit/miss events from two players onto one shared score-counter
// update bus, and forwards newly earned blocking lines to the opponent board.
module arbitro_jogadas #(
  parameter int TIMEOUT_ACK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       jogo_ativo,
  input  logic       acerto_j1,
  input  logic       erro_j1,
  input  logic       acerto_j2,
  input  logic       erro_j2,
  input  logic [2:0] linhas_j1,
  input  logic [2:0] linhas_j2,
  input  logic       bloq_ack,
  output logic       acertou,
  output logic       errou,
  output logic       enable_j1,
  output logic       enable_j2,
  output logic       bloq_req,
  output logic       bloq_alvo,
  output logic [2:0] bloq_qtd,
  output logic       bloq_perdido,
  output logic       ocupado
);

  typedef enum logic [2:0] {OCIOSO, APLICA, ESPERA, COMPARA, BLOQ} estado_t;

  localparam logic [7:0] ULTIMO_CNT = 8'(TIMEOUT_ACK - 1);

  estado_t    state_reg;
  logic [3:0] in_now;
  logic [3:0] in_reg;
  logic [3:0] event_det;
  logic [3:0] pend_reg;
  logic [3:0] pend_clr;
  logic       last_reg;
  logic       sel_reg;
  logic       sel_next;
  logic       req_j1;
  logic       req_j2;
  logic [1:0] clr_idx;
  logic [2:0] linhas_ant_j1_reg;
  logic [2:0] linhas_ant_j2_reg;
  logic [2:0] linhas_cur;
  logic [2:0] linhas_ant_cur;
  logic [2:0] linhas_dif;
  logic [7:0] cnt_reg;

  // Flag index = player*2 + kind, kind 0 = acerto, 1 = erro.
  assign in_now = {erro_j2, acerto_j2, erro_j1, acerto_j1};

  assign req_j1   = |pend_reg[1:0];
  assign req_j2   = |pend_reg[3:2];
  assign sel_next = (req_j1 && req_j2) ? ~last_reg : req_j2;
  assign clr_idx  = {sel_reg, ~pend_reg[{sel_reg, 1'b0}]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign event_det[gi] = jogo_ativo & in_now[gi] & ~in_reg[gi];
      assign pend_clr[gi]  = (state_reg == APLICA) && (clr_idx == 2'(gi));
    end
  endgenerate

  assign linhas_cur     = sel_reg ? linhas_j2 : linhas_j1;
  assign linhas_ant_cur = sel_reg ? linhas_ant_j2_reg : linhas_ant_j1_reg;
  assign linhas_dif     = linhas_cur - linhas_ant_cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= OCIOSO;
      in_reg            <= '0;
      pend_reg          <= '0;
      last_reg          <= 1'b1;
      sel_reg           <= 1'b0;
      linhas_ant_j1_reg <= '0;
      linhas_ant_j2_reg <= '0;
      cnt_reg           <= '0;
      acertou           <= 1'b0;
      errou             <= 1'b0;
      enable_j1         <= 1'b0;
      enable_j2         <= 1'b0;
      bloq_req          <= 1'b0;
      bloq_alvo         <= 1'b0;
      bloq_qtd          <= '0;
      bloq_perdido      <= 1'b0;
      ocupado           <= 1'b0;
    end else begin
      in_reg       <= in_now;
      acertou      <= 1'b0;
      errou        <= 1'b0;
      enable_j1    <= 1'b0;
      enable_j2    <= 1'b0;
      bloq_perdido <= 1'b0;
      if (!jogo_ativo) begin
        state_reg         <= OCIOSO;
        pend_reg          <= '0;
        linhas_ant_j1_reg <= linhas_j1;
        linhas_ant_j2_reg <= linhas_j2;
        bloq_req          <= 1'b0;
        bloq_alvo         <= 1'b0;
        bloq_qtd          <= '0;
        ocupado           <= 1'b0;
      end else begin
        // A new event on a flag being served in the same cycle survives.
        pend_reg <= (pend_reg & ~pend_clr) | event_det;
        case (state_reg)
          OCIOSO: begin
            if (|pend_reg) begin
              sel_reg   <= sel_next;
              state_reg <= APLICA;
              ocupado   <= 1'b1;
            end
          end
          APLICA: begin
            acertou   <= ~clr_idx[0];
            errou     <= clr_idx[0];
            enable_j1 <= ~sel_reg;
            enable_j2 <= sel_reg;
            last_reg  <= sel_reg;
            state_reg <= ESPERA;
          end
          ESPERA: state_reg <= COMPARA;
          COMPARA: begin
            if (sel_reg) linhas_ant_j2_reg <= linhas_j2;
            else         linhas_ant_j1_reg <= linhas_j1;
            if (linhas_cur > linhas_ant_cur) begin
              bloq_req  <= 1'b1;
              bloq_alvo <= ~sel_reg;
              bloq_qtd  <= linhas_dif;
              cnt_reg   <= '0;
              state_reg <= BLOQ;
            end else begin
              state_reg <= OCIOSO;
              ocupado   <= 1'b0;
            end
          end
          BLOQ: begin
            if (bloq_ack || cnt_reg == ULTIMO_CNT) begin
              bloq_req     <= 1'b0;
              bloq_alvo    <= 1'b0;
              bloq_qtd     <= '0;
              bloq_perdido <= ~bloq_ack;
              state_reg    <= OCIOSO;
              ocupado      <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
          default: begin
            state_reg <= OCIOSO;
            ocupado   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arbitro_jogadas.sv
// Directed scenarios plus randomized traffic for arbitro_jogadas, checked every
// cycle against a timeline model of each service (select, pulse, settle, compare, push).
module tb_arbitro_jogadas;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       jogo_ativo = 1'b1;
  logic       acerto_j1 = 1'b0, erro_j1 = 1'b0, acerto_j2 = 1'b0, erro_j2 = 1'b0;
  logic [2:0] linhas_j1 = '0, linhas_j2 = '0;
  logic       bloq_ack = 1'b0;
  logic       acertou, errou, enable_j1, enable_j2, bloq_req, bloq_alvo;
  logic [2:0] bloq_qtd;
  logic       bloq_perdido, ocupado;

  int n_cmp = 0;
  int n_fail = 0;

  arbitro_jogadas #(.TIMEOUT_ACK(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .jogo_ativo(jogo_ativo),
    .acerto_j1(acerto_j1), .erro_j1(erro_j1), .acerto_j2(acerto_j2), .erro_j2(erro_j2),
    .linhas_j1(linhas_j1), .linhas_j2(linhas_j2), .bloq_ack(bloq_ack),
    .acertou(acertou), .errou(errou), .enable_j1(enable_j1), .enable_j2(enable_j2),
    .bloq_req(bloq_req), .bloq_alvo(bloq_alvo), .bloq_qtd(bloq_qtd),
    .bloq_perdido(bloq_perdido), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending events per (player, kind); a service is a
  // timeline measured in cycles since the player was chosen.
  bit         m_pend[4];
  logic [3:0] m_prev;
  int         m_lin[2];
  int         m_phase, m_who, m_age, m_last, m_clear, m_kind, m_cur;
  logic [3:0] m_now;
  bit         e_ac, e_er, e_en1, e_en2, e_req, e_alvo, e_lost, e_busy;
  int         e_qtd;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_prev = '0; m_lin[0] = 0; m_lin[1] = 0;
    m_phase = 0; m_who = 0; m_age = 0; m_last = 1;
    e_ac = 0; e_er = 0; e_en1 = 0; e_en2 = 0; e_req = 0; e_alvo = 0;
    e_qtd = 0; e_lost = 0; e_busy = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        m_now = {erro_j2, acerto_j2, erro_j1, acerto_j1};
        e_ac = 0; e_er = 0; e_en1 = 0; e_en2 = 0; e_lost = 0;
        if (!jogo_ativo) begin
          for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
          m_lin[0] = int'(linhas_j1); m_lin[1] = int'(linhas_j2);
          m_phase = 0; e_req = 0; e_alvo = 0; e_qtd = 0;
        end else begin
          m_clear = -1;
          if (m_phase == 0) begin
            bit r1, r2;
            r1 = m_pend[0] | m_pend[1];
            r2 = m_pend[2] | m_pend[3];
            if (r1 || r2) begin
              m_who = (r1 && r2) ? 1 - m_last : (r1 ? 0 : 1);
              m_phase = 1;
            end
          end else if (m_phase == 1) begin
            m_kind = m_pend[m_who * 2] ? 0 : 1;
            m_clear = m_who * 2 + m_kind;
            e_ac = (m_kind == 0); e_er = (m_kind == 1);
            e_en1 = (m_who == 0); e_en2 = (m_who == 1);
            m_last = m_who;
            m_phase = 2;
          end else if (m_phase == 2) begin
            m_phase = 3;
          end else if (m_phase == 3) begin
            m_cur = (m_who == 1) ? int'(linhas_j2) : int'(linhas_j1);
            if (m_cur > m_lin[m_who]) begin
              e_req = 1; e_alvo = (m_who == 0); e_qtd = m_cur - m_lin[m_who];
              m_age = 0; m_phase = 4;
            end else begin
              m_phase = 0;
            end
            m_lin[m_who] = m_cur;
          end else begin
            if (bloq_ack || m_age == TIMEOUT - 1) begin
              e_lost = !bloq_ack;
              e_req = 0; e_alvo = 0; e_qtd = 0; m_phase = 0;
            end else begin
              m_age++;
            end
          end
          for (int i = 0; i < 4; i++) begin
            if (i == m_clear) m_pend[i] = 1'b0;
            if (m_now[i] && !m_prev[i]) m_pend[i] = 1'b1;
          end
        end
        m_prev = m_now;
        e_busy = (m_phase != 0);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [10:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      exp_v = {e_ac, e_er, e_en1, e_en2, e_req, e_alvo, 3'(e_qtd), e_lost, e_busy};
      act_v = {acertou, errou, enable_j1, enable_j2, bloq_req, bloq_alvo, bloq_qtd,
               bloq_perdido, ocupado};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle outputs {ac,er,en1,en2,req,alvo,qtd,lost,busy}: got %b expected %b (t=%0t)",
                 act_v, exp_v, $time);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset: all outputs low.
    cycles(3);
    check("reset_outputs", int'({acertou, errou, enable_j1, enable_j2, bloq_req,
          bloq_alvo, bloq_qtd, bloq_perdido, ocupado}), 0);
    reset_n = 1'b1;
    cycles(2);

    // Tie right after reset: player 1 first, player 2 four cycles later.
    acerto_j1 = 1'b1; acerto_j2 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("tie_first_en1", int'(enable_j1), 1);
    check("tie_first_en2", int'(enable_j2), 0);
    check("tie_first_acertou", int'(acertou), 1);
    repeat (4) @(posedge clk); #1;
    check("tie_second_en2", int'(enable_j2), 1);
    check("tie_second_acertou", int'(acertou), 1);
    $display("tie: players served in order 1 then 2");
    @(negedge clk); acerto_j1 = 1'b0; acerto_j2 = 1'b0;
    cycles(6);

    // Single hit: one-cycle pulse two edges after detection.
    acerto_j1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("hit_acertou", int'(acertou), 1);
    check("hit_en1", int'(enable_j1), 1);
    check("hit_errou", int'(errou), 0);
    check("hit_en2", int'(enable_j2), 0);
    @(posedge clk); #1;
    check("hit_pulse_width", int'(acertou), 0);
    $display("single hit: player 1 acerto applied");
    @(negedge clk); acerto_j1 = 1'b0;
    cycles(6);

    // Block push acknowledged.
    acerto_j1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); linhas_j1 = 3'd1;
    repeat (2) @(posedge clk); #1;
    check("push_req", int'(bloq_req), 1);
    check("push_alvo", int'(bloq_alvo), 1);
    check("push_qtd", int'(bloq_qtd), 1);
    repeat (3) @(posedge clk); #1;
    check("push_held_qtd", int'(bloq_qtd), 1);
    @(negedge clk); bloq_ack = 1'b1;
    @(posedge clk); #1;
    check("push_ack_drop", int'(bloq_req), 0);
    check("push_ack_idle", int'(ocupado), 0);
    $display("push: 1 line to player 2 acknowledged");
    @(negedge clk); bloq_ack = 1'b0; acerto_j1 = 1'b0;
    cycles(4);

    // Block push timing out.
    acerto_j2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); linhas_j2 = 3'd3;
    repeat (2) @(posedge clk); #1;
    check("tmo_qtd", int'(bloq_qtd), 3);
    check("tmo_alvo", int'(bloq_alvo), 0);
    repeat (TIMEOUT - 1) @(posedge clk); #1;
    check("tmo_still_req", int'(bloq_req), 1);
    @(posedge clk); #1;
    check("tmo_req_drop", int'(bloq_req), 0);
    check("tmo_lost", int'(bloq_perdido), 1);
    check("tmo_idle", int'(ocupado), 0);
    @(posedge clk); #1;
    check("tmo_lost_width", int'(bloq_perdido), 0);
    $display("push: 3 lines to player 1 timed out");
    @(negedge clk); acerto_j2 = 1'b0;
    cycles(4);

    // Abort during a push, with an event pending.
    acerto_j1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); linhas_j1 = 3'd2;
    repeat (2) @(posedge clk); #1;
    check("abort_push_req", int'(bloq_req), 1);
    @(negedge clk); erro_j2 = 1'b1;
    @(negedge clk); jogo_ativo = 1'b0;
    @(posedge clk); #1;
    check("abort_req_drop", int'(bloq_req), 0);
    check("abort_idle", int'(ocupado), 0);
    @(negedge clk); jogo_ativo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_pending_cleared", int'(errou), 0);
    end
    $display("abort: push dropped and pending erro discarded");
    @(negedge clk); acerto_j1 = 1'b0; erro_j2 = 1'b0;
    cycles(4);

    // Asynchronous reset in the middle of a pulse.
    acerto_j1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("areset_before", int'(acertou), 1);
    #1 reset_n = 1'b0;
    #1;
    check("areset_acertou", int'(acertou), 0);
    check("areset_en1", int'(enable_j1), 0);
    $display("async reset: pulse cleared without a clock edge");
    cycles(2);
    acerto_j1 = 1'b0;
    reset_n = 1'b1;
    cycles(2);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) acerto_j1 = ~acerto_j1;
      if ($urandom_range(0, 3) == 0) erro_j1 = ~erro_j1;
      if ($urandom_range(0, 3) == 0) acerto_j2 = ~acerto_j2;
      if ($urandom_range(0, 3) == 0) erro_j2 = ~erro_j2;
      if (jogo_ativo) jogo_ativo = ($urandom_range(0, 99) != 0);
      else            jogo_ativo = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) linhas_j1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) linhas_j2 = 3'($urandom_range(0, 7));
      bloq_ack = ($urandom_range(0, 9) == 0);
    end
    $display("random: 4000 cycles of mixed traffic");
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
